// File: rtl/block_game_ctrl.sv
// block_game_ctrl: two-player block game sequencer and row-write scheduler.
// Owns the game FSM, scores and moving-block column, and keeps the 8-row
// display block array current through a single-port row-write interface,
// writing the lowest-index dirty row whenever the array is ready.
module block_game_ctrl #(
  parameter int TARGET_COL = 4,
  parameter int WIN_SCORE  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       tick,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       wr_ready,
  output logic       wr_strobe,
  output logic [2:0] wr_row,
  output logic [7:0] wr_data,
  output logic [1:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] block_col
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [2:0] TGT = 3'(TARGET_COL);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] p1_d;
  logic [3:0] p2_d;
  logic [2:0] col_d;
  logic [7:0] dirty_q;
  logic [7:0] dirty_set;
  logic [7:0] dirty_clr;
  logic [7:0] dirty_d;
  logic       issue_vld_p0;
  logic [2:0] issue_row_p0;

  // Row image as the VGA block array should show it for the given game state.
  function automatic logic [7:0] row_contents(input state_t st, input logic [2:0] row,
                                              input logic [3:0] s1, input logic [3:0] s2,
                                              input logic [2:0] col);
    logic [7:0] r;
    r = 8'h00;
    case (st)
      QI:    r = 8'h00;
      QDONE: r = 8'hFF;
      default: begin
        case (row)
          3'd0:    r = {s2, s1};
          3'd3:    r = 8'h01 << col;
          3'd5:    r = 8'h01 << TGT;
          default: r = 8'h00;
        endcase
      end
    endcase
    return r;
  endfunction

  // Game FSM next state, score/column updates and the rows they dirty.
  always_comb begin
    state_d   = state_q;
    p1_d      = p1_score;
    p2_d      = p2_score;
    col_d     = block_col;
    dirty_set = 8'h00;
    case (state_q)
      QI: begin
        p1_d  = 4'd0;
        p2_d  = 4'd0;
        col_d = 3'd0;
        if (start) state_d = QGAME_1;
      end
      QGAME_1, QGAME_2: begin
        if (!start) begin
          state_d = QI;
          p1_d    = 4'd0;
          p2_d    = 4'd0;
          col_d   = 3'd0;
        end else begin
          if (tick) begin
            col_d        = block_col + 3'd1;
            dirty_set[3] = 1'b1;
          end
          // Hit test uses the column before any same-cycle tick.
          if (state_q == QGAME_1 && btn_p1) begin
            if (block_col == TGT) begin
              p1_d         = p1_score + 4'd1;
              dirty_set[0] = 1'b1;
            end
            state_d = (p1_d == WIN) ? QDONE : QGAME_2;
          end
          if (state_q == QGAME_2 && btn_p2) begin
            if (block_col == TGT) begin
              p2_d         = p2_score + 4'd1;
              dirty_set[0] = 1'b1;
            end
            state_d = (p2_d == WIN) ? QDONE : QGAME_1;
          end
        end
      end
      QDONE: begin
        if (!start) begin
          state_d = QI;
          p1_d    = 4'd0;
          p2_d    = 4'd0;
          col_d   = 3'd0;
        end
      end
      default: state_d = QI;
    endcase
    // Any state change repaints the whole array.
    if (state_d != state_q) dirty_set = 8'hFF;
  end

  // Pick the lowest dirty row; a same-cycle set of a bit wins over its clear.
  always_comb begin
    issue_row_p0 = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dirty_q[i]) issue_row_p0 = 3'(i);
    end
    issue_vld_p0 = wr_ready && (dirty_q != 8'h00);
    dirty_clr    = issue_vld_p0 ? (8'h01 << issue_row_p0) : 8'h00;
    dirty_d      = (dirty_q & ~dirty_clr) | dirty_set;
  end

  // Game registers and dirty mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= QI;
      p1_score  <= 4'd0;
      p2_score  <= 4'd0;
      block_col <= 3'd0;
      dirty_q   <= 8'hFF;
    end else begin
      state_q   <= state_d;
      p1_score  <= p1_d;
      p2_score  <= p2_d;
      block_col <= col_d;
      dirty_q   <= dirty_d;
    end
  end

  // ---- write port stage: registered strobe, row and data ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_strobe <= 1'b0;
      wr_row    <= 3'd0;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= issue_vld_p0;
      if (issue_vld_p0) begin
        wr_row  <= issue_row_p0;
        wr_data <= row_contents(state_q, issue_row_p0, p1_score, p2_score, block_col);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_block_game_ctrl.sv
// Testbench for block_game_ctrl: directed vector table plus hand sequences
// for winning, QDONE/QI repaint and asynchronous reset during a refresh.
module tb_block_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, tick, btn_p1, btn_p2, wr_ready;
  logic       wr_strobe;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic [1:0] state;
  logic [3:0] p1_score, p2_score;
  logic [2:0] block_col;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st, tk, b1, b2, rdy;
    logic       estb;
    logic [2:0] erow;
    logic [7:0] edata;
    logic [1:0] estate;
    logic [3:0] ep1, ep2;
    logic [2:0] ecol;
  } vec_t;

  vec_t vecs[$];

  block_game_ctrl #(.TARGET_COL(4), .WIN_SCORE(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
    .btn_p1(btn_p1), .btn_p2(btn_p2), .wr_ready(wr_ready),
    .wr_strobe(wr_strobe), .wr_row(wr_row), .wr_data(wr_data),
    .state(state), .p1_score(p1_score), .p2_score(p2_score),
    .block_col(block_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic st, tk, b1, b2, rdy, input logic estb,
                              input logic [2:0] erow, input logic [7:0] edata,
                              input logic [1:0] estate, input logic [3:0] ep1, ep2,
                              input logic [2:0] ecol);
    vec_t v;
    v.st = st; v.tk = tk; v.b1 = b1; v.b2 = b2; v.rdy = rdy;
    v.estb = estb; v.erow = erow; v.edata = edata;
    v.estate = estate; v.ep1 = ep1; v.ep2 = ep2; v.ecol = ecol;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic st, tk, b1, b2, rdy);
    @(negedge clk);
    start = st; tick = tk; btn_p1 = b1; btn_p2 = b2; wr_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_refresh(input logic st, input logic [7:0] d, input string tag);
    for (int r = 0; r < 8; r++) begin
      step(st, 1'b1, 1'b1, 1'b1, 1'b1);
      chk({tag, "_strobe"}, 32'(wr_strobe), 32'd1);
      chk({tag, "_row"}, 32'(wr_row), 32'(r));
      chk({tag, "_data"}, 32'(wr_data), 32'(d));
    end
  endtask

  initial begin
    logic [7:0] game_rows [8];
    logic [7:0] bp_rows [8];
    game_rows = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00};
    bp_rows   = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h00, 8'h10, 8'h00, 8'h00};

    // Reset refresh, start (tick on entry edge ignored), first game refresh.
    for (int i = 0; i < 8; i++) add(0,0,0,0,1, 1,3'(i),8'h00, 2'd0,0,0,0);
    add(0,0,0,0,1, 0,0,0, 2'd0,0,0,0);
    add(1,1,0,0,1, 0,0,0, 2'd1,0,0,0);
    for (int i = 0; i < 8; i++) add(1,0,0,0,1, 1,3'(i),game_rows[i], 2'd1,0,0,0);
    // Sweep: row 3 follows the column.
    add(1,1,0,0,1, 0,0,0,     2'd1,0,0,1);
    add(1,1,0,0,1, 1,3,8'h02, 2'd1,0,0,2);
    add(1,1,0,0,1, 1,3,8'h04, 2'd1,0,0,3);
    add(1,1,0,0,1, 1,3,8'h08, 2'd1,0,0,4);
    // P1 hit at column 4, then P1 ignored, P2 tick to 5, P2 miss.
    add(1,0,1,0,1, 1,3,8'h10, 2'd2,1,0,4);
    add(1,0,1,0,1, 1,0,8'h01, 2'd2,1,0,4);
    add(1,1,0,0,1, 1,1,8'h00, 2'd2,1,0,5);
    add(1,0,0,1,1, 1,2,8'h00, 2'd1,1,0,5);
    // Backpressure: ticks wrap 5->6->7->0->...->4, no strobes.
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,6);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,7);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,0);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,1);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,2);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,3);
    add(1,1,0,0,0, 0,0,0, 2'd1,1,0,4);
    // Tick and hit together: pre-tick column scores, column becomes 5.
    add(1,1,1,0,0, 0,0,0, 2'd2,2,0,5);
    for (int i = 0; i < 8; i++) add(1,0,0,0,1, 1,3'(i),bp_rows[i], 2'd2,2,0,5);
    add(1,0,0,0,1, 0,0,0, 2'd2,2,0,5);
    // Abort mid-game, then QI repaint with tick ignored.
    add(0,0,0,0,1, 0,0,0, 2'd0,0,0,0);
    add(0,1,0,0,1, 1,0,8'h00, 2'd0,0,0,0);
    for (int i = 1; i < 8; i++) add(0,0,0,0,1, 1,3'(i),8'h00, 2'd0,0,0,0);

    reset_n = 1'b0;
    start = 0; tick = 0; btn_p1 = 0; btn_p2 = 0; wr_ready = 0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_row", 32'(wr_row), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_p1", 32'(p1_score), 32'd0);
    chk("rst_p2", 32'(p2_score), 32'd0);
    chk("rst_col", 32'(block_col), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].st, vecs[k].tk, vecs[k].b1, vecs[k].b2, vecs[k].rdy);
      chk($sformatf("v%0d_strobe", k), 32'(wr_strobe), 32'(vecs[k].estb));
      if (vecs[k].estb) begin
        chk($sformatf("v%0d_row", k), 32'(wr_row), 32'(vecs[k].erow));
        chk($sformatf("v%0d_data", k), 32'(wr_data), 32'(vecs[k].edata));
      end
      chk($sformatf("v%0d_state", k), 32'(state), 32'(vecs[k].estate));
      chk($sformatf("v%0d_p1", k), 32'(p1_score), 32'(vecs[k].ep1));
      chk($sformatf("v%0d_p2", k), 32'(p2_score), 32'(vecs[k].ep2));
      chk($sformatf("v%0d_col", k), 32'(block_col), 32'(vecs[k].ecol));
    end

    // Win: P1 hits every turn, P2 always misses at column 5.
    step(1,0,0,0,1);
    chk("win_enter", 32'(state), 32'd1);
    for (int r = 1; r <= 9; r++) begin
      repeat (4) step(1,1,0,0,1);
      step(1,0,1,0,1);
      chk($sformatf("win_r%0d_p1", r), 32'(p1_score), 32'(r));
      chk($sformatf("win_r%0d_state", r), 32'(state), 32'd2);
      step(1,1,0,0,1);
      step(1,0,0,1,1);
      chk($sformatf("win_r%0d_p2", r), 32'(p2_score), 32'd0);
      repeat (3) step(1,1,0,0,1);
    end
    repeat (4) step(1,1,0,0,1);
    chk("win_col", 32'(block_col), 32'd4);
    step(1,0,1,0,1);
    chk("win_p1", 32'(p1_score), 32'hA);
    chk("win_state", 32'(state), 32'd3);
    expect_refresh(1'b1, 8'hFF, "done");
    chk("done_col", 32'(block_col), 32'd4);
    chk("done_p1", 32'(p1_score), 32'hA);
    chk("done_state", 32'(state), 32'd3);
    step(1,0,0,0,1);
    chk("done_idle", 32'(wr_strobe), 32'd0);
    step(0,0,0,0,1);
    chk("done_to_qi", 32'(state), 32'd0);
    chk("done_p1_clr", 32'(p1_score), 32'd0);
    expect_refresh(1'b0, 8'h00, "qi");

    // Asynchronous reset in the middle of a refresh.
    step(1,0,0,0,1);
    step(1,0,0,0,1);
    step(1,0,0,0,1);
    step(1,0,0,0,1);
    chk("mid_strobe", 32'(wr_strobe), 32'd1);
    chk("mid_row", 32'(wr_row), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_strobe", 32'(wr_strobe), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_row", 32'(wr_row), 32'd0);
    @(negedge clk);
    start = 0; wr_ready = 0;
    reset_n = 1'b1;
    step(0,0,0,0,1);
    chk("post_rst_row0", 32'(wr_row), 32'd0);
    chk("post_rst_strobe", 32'(wr_strobe), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
